// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl -- command/register controller behind a byte-oriented SPI slave.
// Every transfer (ssel_active high) starts with a command byte. Its fields select
// write/read, auto-increment and a start address. The data bytes that follow are
// written into, or read out of, a small register file. Address 7 is a read-only
// view of the illegal-command counter.
// Ports:
//   clk, rst_n   system clock (rising edge), async active-low reset
//   ssel_active  synchronized chip-select, high while a transfer is open
//   rx_valid     one-cycle strobe, rx_data holds a complete received byte
//   rx_data      received byte
//   tx_data      registered byte the slave shifts out next
//   led          reg[0] bit 0
//   ctrl_out     reg[1]
//   err_cnt      saturating count of illegal commands
//   state_o      FSM state, for debug
module spi_cmd_ctrl #(
  parameter logic [7:0] STATUS_BYTE = 8'hA5,
  parameter logic [7:0] ERR_BYTE    = 8'hEE,
  parameter logic [7:0] CTRL_RST    = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ssel_active,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic [7:0] tx_data,
  output logic       led,
  output logic [7:0] ctrl_out,
  output logic [7:0] err_cnt,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    WR   = 3'd2,
    RD   = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t          state;
  logic [2:0]      addr;
  logic            ai;
  logic [6:0][7:0] regs;

  logic [2:0]      nxt_addr;
  logic [7:0]      rd_start;
  logic [7:0]      rd_next;

  // Read mux over registered state only: a read never sees a same-cycle write.
  always_comb begin
    nxt_addr = ai ? addr + 3'd1 : addr;   // 3-bit add wraps 7 -> 0
    rd_start = (rx_data[2:0] == 3'd7) ? err_cnt : regs[rx_data[2:0]];
    rd_next  = (nxt_addr == 3'd7)     ? err_cnt : regs[nxt_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr    <= 3'd0;
      ai      <= 1'b0;
      regs    <= {7{CTRL_RST}};
      err_cnt <= 8'h00;
      tx_data <= STATUS_BYTE;
    end else if (!ssel_active) begin
      // Chip-select low wins over a coincident rx_valid: that byte is dropped.
      state   <= IDLE;
      tx_data <= STATUS_BYTE;
    end else begin
      case (state)
        IDLE: begin
          state   <= CMD;
          tx_data <= STATUS_BYTE;
        end
        CMD: if (rx_valid) begin
          ai   <= rx_data[6];
          addr <= rx_data[2:0];
          if (rx_data[5:3] != 3'b000) begin
            state   <= ERR;
            tx_data <= ERR_BYTE;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          end else if (rx_data[7]) begin
            state   <= WR;
            tx_data <= STATUS_BYTE;
          end else begin
            state   <= RD;
            tx_data <= rd_start;
          end
        end
        WR: if (rx_valid) begin
          if (addr != 3'd7) regs[addr] <= rx_data;  // address 7 silently ignored
          tx_data <= rx_data;
          addr    <= nxt_addr;
        end
        RD: if (rx_valid) begin
          // Dummy byte: step first, then present the new location.
          addr    <= nxt_addr;
          tx_data <= rd_next;
        end
        ERR: tx_data <= ERR_BYTE;
        default: begin
          state   <= IDLE;
          tx_data <= STATUS_BYTE;
        end
      endcase
    end
  end

  assign led      = regs[0][0];
  assign ctrl_out = regs[1];
  assign state_o  = state;

endmodule

// File: doc/spi_cmd_ctrl.md
SPI_CMD_CTRL -- requirements
Module: spi_cmd_ctrl

Interface
REQ-001 SHALL have parameter STATUS_BYTE, default 8'hA5, meaning the byte presented on tx_data while a command byte is being received.
REQ-002 SHALL have parameter ERR_BYTE, default 8'hEE, meaning the byte presented on tx_data after an illegal command.
REQ-003 SHALL have parameter CTRL_RST, default 8'h00, meaning the reset value of registers 0-6.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock, rising-edge active.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous assertion, active-low.
REQ-006 SHALL have port ssel_active, input, 1 bit: synchronized chip-select from the SPI slave, high while a transfer is open.
REQ-007 SHALL have port rx_valid, input, 1 bit: one-cycle pulse that marks a complete received byte.
REQ-008 SHALL have port rx_data, input, 8 bits: the received byte, valid when rx_valid is high.
REQ-009 SHALL have port tx_data, output, 8 bits: the next byte the SPI slave shifts out MSB-first.
REQ-010 SHALL have port led, output, 1 bit: equal to reg[0] bit 0.
REQ-011 SHALL have port ctrl_out, output, 8 bits: equal to reg[1].
REQ-012 SHALL have port err_cnt, output, 8 bits: the count of illegal commands.
REQ-013 SHALL have port state_o, output, 3 bits: the current FSM state encoding, for debug.

Function
REQ-014 SHALL implement register file reg[0..6], each 8 bits and read/write; address 7 SHALL be read-only and SHALL return err_cnt.
REQ-015 SHALL implement the FSM states IDLE=0, CMD=1, WR=2, RD=3 and ERR=4.
REQ-016 SHALL apply the transitions:
- from any state to IDLE when ssel_active=0;
- IDLE to CMD when ssel_active=1;
- CMD to WR, RD or ERR on rx_valid, according to the command decode.
REQ-017 SHALL give ssel_active=0 priority over rx_valid in the same cycle: the byte is discarded, with no register write and no address change.
REQ-018 SHALL decode the command byte as follows:
- bit7: 1=write, 0=read;
- bit6: auto-increment enable;
- bits[5:3]: must be 000, otherwise the command is illegal and the FSM goes to ERR;
- bits[2:0]: start address.
REQ-019 SHALL, in WR, on each rx_valid, write rx_data to reg[addr] on the next clock edge; writes to address 7 SHALL be ignored without error.
REQ-020 SHALL, in RD, on each rx_valid (dummy byte), advance addr when auto-increment is set and then present reg[new addr] on tx_data.
REQ-021 SHALL wrap address 7 to 0 on auto-increment; with auto-increment clear, addr SHALL stay fixed for the whole transfer.
REQ-022 SHALL drive tx_data as follows, registered and updated one clk after the triggering event:
- IDLE, CMD: STATUS_BYTE;
- WR: echo of the last received byte;
- RD: reg[addr];
- ERR: ERR_BYTE.
REQ-023 SHALL, on CMD to RD, load tx_data with reg[start address] one cycle after rx_valid.
REQ-024 SHALL, in ERR, ignore all further bytes until ssel_active=0.
REQ-025 SHALL increment err_cnt by 1 on each entry into ERR, saturating at 8'hFF.
REQ-026 SHALL give a read in RD the registered value: a write from an earlier transfer is visible; there is no same-cycle bypass.
REQ-027 SHALL change led and ctrl_out one clk after the write edge, and only on writes to addresses 0 and 1 respectively.

Reset
REQ-028 SHALL, on rst_n=0, immediately force:
- state to IDLE and addr to 0;
- reg[0..6] to CTRL_RST;
- err_cnt to 0 and tx_data to STATUS_BYTE;
- led to CTRL_RST[0] and ctrl_out to CTRL_RST.
REQ-029 SHALL, on reset mid-transfer, abort the transfer; after release the FSM SHALL wait in IDLE (or CMD if ssel_active=1) for a new command byte.

Verification
REQ-030 Write with auto-increment: ssel=1; bytes C0,11,22,33 -> reg0=11, reg1=22, reg2=33, led=1, ctrl_out=22, tx_data sequence A5,11,22,33.
REQ-031 Read with auto-increment and wrap: after REQ-030, set reg6=66, then bytes 46,00,00 -> tx_data 66, then 0 (err_cnt), then 11.
REQ-032 Illegal command: byte 88 then 55 -> state ERR, tx_data=EE, reg unchanged, err_cnt=1; ssel=0 -> IDLE; 256 more illegal commands -> err_cnt=FF.
REQ-033 Fixed address: byte 81 then 01,02,03 -> reg1=03, reg2 unchanged; writing 87 then AA -> reg7 read still returns err_cnt.
REQ-034 Simultaneous event: ssel_active falls in the same cycle as rx_valid during WR -> no write, state IDLE.
REQ-035 Async reset mid-RD: assert rst_n=0 between clock edges -> outputs reach their reset values without waiting for a clk edge; the next transfer decodes its first byte as a command.
